// File: rtl/sect_pt_mul_mc.sv
// Purpose: multi-channel front-end that queues scalar requests and shares one point-multiply core among them,
//          adding zero-scalar bypass, a per-job watchdog and a global flush.
// Latency: accept -> core_start 2 cycles minimum; core_done -> rsp_valid 1 cycle; d==0 -> rsp_valid 1 cycle.
// Backpressure: one outstanding job per channel; req_ready[i] stays low until that channel's result is taken.
// Ports: clk/rst (sync, active-high), flush; req_valid/req_ready/req_d per channel; rsp_valid/rsp_ready/
//        rsp_x/rsp_y/rsp_inf/rsp_err per channel; core_clr/core_start/core_d/core_done/core_x/core_y to the
//        core; busy and grant_ch status.
module sect_pt_mul_mc #(
    parameter int M           = 233,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NUM_CH-1:0]      req_valid,
    output logic [NUM_CH-1:0]      req_ready,
    input  logic [NUM_CH*M-1:0]    req_d,
    output logic [NUM_CH-1:0]      rsp_valid,
    input  logic [NUM_CH-1:0]      rsp_ready,
    output logic [NUM_CH*M-1:0]    rsp_x,
    output logic [NUM_CH*M-1:0]    rsp_y,
    output logic [NUM_CH-1:0]      rsp_inf,
    output logic [NUM_CH-1:0]      rsp_err,
    output logic                   core_clr,
    output logic                   core_start,
    output logic [M-1:0]           core_d,
    input  logic                   core_done,
    input  logic [M-1:0]           core_x,
    input  logic [M-1:0]           core_y,
    output logic                   busy,
    output logic [CH_W-1:0]        grant_ch
);

    typedef enum logic [1:0] {CH_IDLE, CH_PEND, CH_RUN, CH_DONE} ch_st_t;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ABORT} core_st_t;

    // Watchdog fires when the counter has seen TIMEOUT_CYC wait cycles (0 .. TIMEOUT_CYC-1).
    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYC - 1);

    ch_st_t          r_ch_st [NUM_CH];
    logic [M-1:0]    r_d     [NUM_CH];
    logic [M-1:0]    r_x     [NUM_CH];
    logic [M-1:0]    r_y     [NUM_CH];
    logic [NUM_CH-1:0] r_inf;
    logic [NUM_CH-1:0] r_err;

    core_st_t        r_cst;
    core_st_t        w_cst_nxt;
    logic [15:0]     r_cnt;
    logic [CH_W-1:0] r_grant;      // last granted channel; owner of the core while busy
    logic            r_start;
    logic            r_flush_clr;

    logic            w_found;
    logic [CH_W-1:0] w_win;
    logic            w_dispatch;
    logic            w_complete;
    logic            w_abort;

    always_ff @(posedge clk) begin
        if (rst) r_cst <= C_IDLE;
        else     r_cst <= w_cst_nxt;
    end

    always_comb begin
        w_cst_nxt  = r_cst;
        w_found    = 1'b0;
        w_win      = r_grant;
        w_dispatch = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        // Round-robin: first pending channel starting just after the previous grant.
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && r_ch_st[(int'(r_grant) + k) % NUM_CH] == CH_PEND) begin
                w_found = 1'b1;
                w_win   = CH_W'((int'(r_grant) + k) % NUM_CH);
            end
        end
        case (r_cst)
            C_IDLE: begin
                if (w_found) begin
                    w_dispatch = 1'b1;
                    w_cst_nxt  = C_WAIT;
                end
            end
            C_WAIT: begin
                // A done arriving on the limit cycle still counts as success.
                if (core_done) begin
                    w_complete = 1'b1;
                    w_cst_nxt  = C_IDLE;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_cst_nxt = C_ABORT;
                end
            end
            C_ABORT: begin
                w_abort   = 1'b1;
                w_cst_nxt = C_IDLE;
            end
            default: w_cst_nxt = C_IDLE;
        endcase
        if (flush) begin
            w_cst_nxt  = C_IDLE;
            w_dispatch = 1'b0;
            w_complete = 1'b0;
            w_abort    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_grant     <= CH_W'(NUM_CH - 1);
            r_start     <= 1'b0;
            r_flush_clr <= 1'b0;
            r_inf       <= '0;
            r_err       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_ch_st[i] <= CH_IDLE;
                r_d[i]     <= '0;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
        end else begin
            r_start     <= w_dispatch;
            r_flush_clr <= flush && (r_cst != C_IDLE);
            if (w_dispatch) begin
                r_grant <= w_win;
                r_cnt   <= '0;
            end else if (r_cst == C_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (flush) begin
                    r_ch_st[i] <= CH_IDLE;
                    r_x[i]     <= '0;
                    r_y[i]     <= '0;
                    r_inf[i]   <= 1'b0;
                    r_err[i]   <= 1'b0;
                end else begin
                    case (r_ch_st[i])
                        CH_IDLE: begin
                            if (req_valid[i]) begin
                                r_d[i] <= req_d[i*M +: M];
                                if (req_d[i*M +: M] != '0) begin
                                    r_ch_st[i] <= CH_PEND;
                                end else begin
                                    // k*G with k=0 is the point at infinity; no core needed.
                                    r_ch_st[i] <= CH_DONE;
                                    r_x[i]     <= '0;
                                    r_y[i]     <= '0;
                                    r_inf[i]   <= 1'b1;
                                    r_err[i]   <= 1'b0;
                                end
                            end
                        end
                        CH_PEND: begin
                            if (w_dispatch && w_win == CH_W'(i)) r_ch_st[i] <= CH_RUN;
                        end
                        CH_RUN: begin
                            if (w_complete && r_grant == CH_W'(i)) begin
                                r_ch_st[i] <= CH_DONE;
                                r_x[i]     <= core_x;
                                r_y[i]     <= core_y;
                                r_inf[i]   <= 1'b0;
                                r_err[i]   <= 1'b0;
                            end else if (w_abort && r_grant == CH_W'(i)) begin
                                r_ch_st[i] <= CH_DONE;
                                r_x[i]     <= '0;
                                r_y[i]     <= '0;
                                r_inf[i]   <= 1'b0;
                                r_err[i]   <= 1'b1;
                            end
                        end
                        CH_DONE: begin
                            if (rsp_ready[i]) r_ch_st[i] <= CH_IDLE;
                        end
                        default: r_ch_st[i] <= CH_IDLE;
                    endcase
                end
            end
        end
    end

    // Every output is forced low while rst is high, even before the first reset edge.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_inf    = '0;
        rsp_err    = '0;
        rsp_x      = '0;
        rsp_y      = '0;
        core_start = !rst && r_start;
        core_clr   = !rst && ((r_cst == C_ABORT) || r_flush_clr);
        busy       = !rst && (r_cst != C_IDLE);
        grant_ch   = busy ? r_grant : '0;
        core_d     = core_start ? r_d[r_grant] : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst) begin
                req_ready[i] = (r_ch_st[i] == CH_IDLE);
                if (r_ch_st[i] == CH_DONE) begin
                    rsp_valid[i]       = 1'b1;
                    rsp_inf[i]         = r_inf[i];
                    rsp_err[i]         = r_err[i];
                    rsp_x[i*M +: M]    = r_x[i];
                    rsp_y[i*M +: M]    = r_y[i];
                end
            end
        end
    end

endmodule
